// File: rtl/shiftregister_framed.sv
// WIDTH-bit framed shift register: MSB/LSB-first shifting, bit counter and word-complete pulse.
// Optional word parity is built only when SHIFTREG_PARITY_EN is defined.
module shiftregister_framed #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  input  logic             lsbFirst,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic [CNTW-1:0]  bitCount,
  output logic             wordDone,
  output logic             wordParity
);

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [WIDTH-1:0] shreg_r;
  logic [CNTW-1:0]  count_r;
  logic             done_r;
  logic [WIDTH-1:0] shift_s;
  logic             shift_en_s;
  logic             wrap_s;

  // Next shifted value and framing decode; a load always masks a shift request
  always_comb begin
    shift_s    = {WIDTH{1'b0}};
    shift_en_s = peripheralClkEdge & ~parallelLoad;
    wrap_s     = 1'b0;
    if (lsbFirst) begin
      shift_s = {serialDataIn, shreg_r[WIDTH-1:1]};
    end else begin
      shift_s = {shreg_r[WIDTH-2:0], serialDataIn};
    end
    if (shift_en_s && (count_r == LAST_BIT)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Shift register, bit counter and word-complete pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {WIDTH{1'b0}};
      count_r <= {CNTW{1'b0}};
      done_r  <= 1'b0;
    end else if (parallelLoad) begin
      shreg_r <= parallelDataIn;
      count_r <= {CNTW{1'b0}};
      done_r  <= 1'b0;
    end else if (peripheralClkEdge) begin
      shreg_r <= shift_s;
      if (wrap_s) begin
        count_r <= {CNTW{1'b0}};
        done_r  <= 1'b1;
      end else begin
        count_r <= count_r + CNT_ONE;
        done_r  <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

`ifdef SHIFTREG_PARITY_EN
  function automatic logic word_xor(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  logic parity_r;

  // Parity of the word just completed; held across loads until the next word completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (wrap_s) begin
      parity_r <= word_xor(shift_s);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign wordParity = parity_r;
`else
  assign wordParity = 1'b0;
`endif

  assign parallelDataOut = shreg_r;
  // Outgoing bit follows lsbFirst immediately, no register stage
  assign serialDataOut   = lsbFirst ? shreg_r[0] : shreg_r[WIDTH-1];
  assign bitCount        = count_r;
  assign wordDone        = done_r;

endmodule

// File: tb/tb_shiftregister_framed.sv
// Directed scoreboard bench for shiftregister_framed (WIDTH=8); parity expectations follow SHIFTREG_PARITY_EN.
module tb_shiftregister_framed;
  localparam int WIDTH = 8;
  localparam int CNTW  = $clog2(WIDTH);
  localparam int S_POUT = 0, S_SOUT = 1, S_CNT = 2, S_DONE = 3, S_PAR = 4;
`ifdef SHIFTREG_PARITY_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             peripheralClkEdge;
  logic             parallelLoad;
  logic [WIDTH-1:0] parallelDataIn;
  logic             serialDataIn;
  logic             lsbFirst;
  logic [WIDTH-1:0] parallelDataOut;
  logic             serialDataOut;
  logic [CNTW-1:0]  bitCount;
  logic             wordDone;
  logic             wordParity;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] pat;

  shiftregister_framed #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .peripheralClkEdge(peripheralClkEdge),
    .parallelLoad(parallelLoad), .parallelDataIn(parallelDataIn),
    .serialDataIn(serialDataIn), .lsbFirst(lsbFirst),
    .parallelDataOut(parallelDataOut), .serialDataOut(serialDataOut),
    .bitCount(bitCount), .wordDone(wordDone), .wordParity(wordParity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input int sel, input logic [31:0] value);
    exp_t e;
    e.tag = tag; e.sel = sel; e.value = value;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_POUT:  return 32'(parallelDataOut);
      S_SOUT:  return 32'(serialDataOut);
      S_CNT:   return 32'(bitCount);
      S_DONE:  return 32'(wordDone);
      S_PAR:   return 32'(wordParity);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.value) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic shift_bit(input logic b);
    peripheralClkEdge = 1'b1;
    serialDataIn      = b;
    @(posedge clk);
    #1;
    peripheralClkEdge = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; peripheralClkEdge = 1'b0; parallelLoad = 1'b0;
    parallelDataIn = 8'h00; serialDataIn = 1'b0; lsbFirst = 1'b0;
    #12;
    expect_out("rst_pout", S_POUT, 32'h0);
    expect_out("rst_sout", S_SOUT, 32'h0);
    expect_out("rst_cnt",  S_CNT,  32'h0);
    expect_out("rst_done", S_DONE, 32'h0);
    expect_out("rst_par",  S_PAR,  32'h0);
    check_sb();
    #4 rst_n = 1'b1;

    // T1 MSB-first word 0xC8
    @(posedge clk); #1;
    pat = 8'hC8;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        expect_out("t1_cnt7", S_CNT, 32'd7);
        expect_out("t1_nodone_early", S_DONE, 32'd0);
        check_sb();
      end
      shift_bit(pat[i]);
    end
    expect_out("t1_pout", S_POUT, 32'hC8);
    expect_out("t1_done", S_DONE, 32'd1);
    expect_out("t1_cnt0", S_CNT,  32'd0);
    expect_out("t1_par",  S_PAR,  32'(PEN));
    check_sb();
    expect_out("t1_done_drop", S_DONE, 32'd0);
    expect_out("t1_hold_pout", S_POUT, 32'hC8);
    expect_out("t1_hold_par",  S_PAR,  32'(PEN));
    tick();

    // T2 LSB-first, same bit sequence
    lsbFirst = 1'b1;
    for (int i = 7; i >= 0; i--) shift_bit(pat[i]);
    expect_out("t2_pout", S_POUT, 32'h13);
    expect_out("t2_sout", S_SOUT, 32'd1);
    expect_out("t2_done", S_DONE, 32'd1);
    expect_out("t2_par",  S_PAR,  32'(PEN));
    check_sb();

    // T6 next word 0x3C clears parity
    lsbFirst = 1'b0;
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) shift_bit(pat[i]);
    expect_out("t6_pout", S_POUT, 32'h3C);
    expect_out("t6_done", S_DONE, 32'd1);
    expect_out("t6_par",  S_PAR,  32'd0);
    check_sb();

    // T3 load and serialize 0x3C
    parallelLoad = 1'b1; parallelDataIn = 8'h3C;
    expect_out("t3_load_pout", S_POUT, 32'h3C);
    expect_out("t3_load_cnt",  S_CNT,  32'd0);
    expect_out("t3_load_done", S_DONE, 32'd0);
    expect_out("t3_load_par",  S_PAR,  32'd0);
    tick();
    parallelLoad = 1'b0;
    pat = 8'b0011_1100;
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("t3_sout%0d", k), S_SOUT, 32'(pat[7-k]));
      if (k > 0) expect_out($sformatf("t3_nodone%0d", k), S_DONE, 32'd0);
      check_sb();
      shift_bit(1'b0);
    end
    expect_out("t3_pout", S_POUT, 32'h00);
    expect_out("t3_done", S_DONE, 32'd1);
    expect_out("t3_cnt",  S_CNT,  32'd0);
    check_sb();

    // T4 load beats shift
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    expect_out("t4_cnt3", S_CNT,  32'd3);
    expect_out("t4_pre",  S_POUT, 32'h05);
    check_sb();
    parallelLoad = 1'b1; peripheralClkEdge = 1'b1; parallelDataIn = 8'h5A; serialDataIn = 1'b1;
    expect_out("t4_pout", S_POUT, 32'h5A);
    expect_out("t4_cnt",  S_CNT,  32'd0);
    expect_out("t4_done", S_DONE, 32'd0);
    tick();
    parallelLoad = 1'b0; peripheralClkEdge = 1'b0;

    // T5 async reset mid-word, then a full word
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    expect_out("t5_cnt5", S_CNT,  32'd5);
    expect_out("t5_pre",  S_POUT, 32'h5F);
    check_sb();
    #2 rst_n = 1'b0;
    #1;
    expect_out("t5_rst_pout", S_POUT, 32'h0);
    expect_out("t5_rst_sout", S_SOUT, 32'h0);
    expect_out("t5_rst_cnt",  S_CNT,  32'h0);
    expect_out("t5_rst_done", S_DONE, 32'h0);
    expect_out("t5_rst_par",  S_PAR,  32'h0);
    check_sb();
    #2 rst_n = 1'b1;
    pat = 8'hB0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        expect_out("t5_cnt7", S_CNT,  32'd7);
        expect_out("t5_nodone7", S_DONE, 32'd0);
        check_sb();
      end
      shift_bit(pat[i]);
    end
    expect_out("t5_pout", S_POUT, 32'hB0);
    expect_out("t5_done", S_DONE, 32'd1);
    expect_out("t5_par",  S_PAR,  32'(PEN));
    check_sb();
    lsbFirst = 1'b1; #1;
    expect_out("sout_lsb", S_SOUT, 32'd0);
    check_sb();
    lsbFirst = 1'b0; #1;
    expect_out("sout_msb", S_SOUT, 32'd1);
    check_sb();
    expect_out("hold_pout", S_POUT, 32'hB0);
    expect_out("hold_cnt",  S_CNT,  32'd0);
    expect_out("hold_done", S_DONE, 32'd0);
    expect_out("hold_par",  S_PAR,  32'(PEN));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
